// File: rtl/pipe_drain_pkg.sv
// Shared widths and reset constants for the pipeline drain buffer.
package pipe_drain_pkg;

  function automatic int clog2_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  localparam int   RST_ZERO = 0;
  localparam logic RST_ERR  = 1'b0;

endpackage

// File: rtl/pipe_drain_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Data words carry no reset; validity is tracked by the owner's counters.
module pipe_drain_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_drain_buf.sv
// Credit-gated drain buffer for a non-stalling pipeline; res-to-out latency 1 cycle.
// A stalled consumer withholds credits, so the upstream pipe never overruns the buffer.
module pipe_drain_buf
  import pipe_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_req,
  output logic                    issue_gnt,
  input  logic                    res_valid,
  input  logic [WIDTH-1:0]        res_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [clog2_w(DEPTH):0] level,
  output logic                    err_unexp
);

  localparam int PW = clog2_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  if (DEPTH < LAT + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_drain_buf: DEPTH must be a power of two and >= LAT+1");
  end

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          err_q, err_d;
  logic          issue_fire, pop_fire, push_fire;

  assign issue_gnt  = (outst_q != C_DEPTH);
  assign out_valid  = (count_q != '0);
  assign level      = count_q;
  assign err_unexp  = err_q;
  assign issue_fire = issue_req && issue_gnt;
  assign pop_fire   = out_valid && out_ready;
  // A result is only accepted against a reservation not yet filled.
  assign push_fire  = res_valid && (outst_q > count_q);

  always_comb begin
    count_d  = count_q;
    outst_d  = outst_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (issue_fire && !pop_fire) outst_d = outst_q + C_ONE;
    if (!issue_fire && pop_fire) outst_d = outst_q - C_ONE;
    if (push_fire && !pop_fire) count_d = count_q + C_ONE;
    if (!push_fire && pop_fire) count_d = count_q - C_ONE;
    if (push_fire) wr_ptr_d = wr_ptr_q + P_ONE;
    if (pop_fire)  rd_ptr_d = rd_ptr_q + P_ONE;
    if (res_valid && !push_fire) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= CW'(RST_ZERO);
      outst_q  <= CW'(RST_ZERO);
      wr_ptr_q <= PW'(RST_ZERO);
      rd_ptr_q <= PW'(RST_ZERO);
      err_q    <= RST_ERR;
    end else begin
      count_q  <= count_d;
      outst_q  <= outst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  pipe_drain_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (res_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

endmodule

// File: tb/tb_pipe_drain_buf.sv
// Directed bench for pipe_drain_buf (WIDTH=8, LAT=2, DEPTH=4).
module tb_pipe_drain_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_req;
  logic       issue_gnt;
  logic       res_valid;
  logic [7:0] res_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic       err_unexp;

  int checks   = 0;
  int failures = 0;

  pipe_drain_buf #(.WIDTH(8), .LAT(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_req (issue_req),
    .issue_gnt (issue_gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gnt_cnt;
    rst_n = 1'b0; issue_req = 1'b0; res_valid = 1'b0; res_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: idle after reset
    chk("rst_gnt",   32'(issue_gnt), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level),     0);
    chk("rst_err",   32'(err_unexp), 0);

    // 2: streaming, result arrives two edges after its issue
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      issue_req = (c < 16);
      res_valid = (c >= 2 && c < 18);
      res_data  = 8'(c - 1);
      chk("stream_gnt",   32'(issue_gnt), 1);
      chk("stream_level", 32'(level <= 3'd1), 1);
      chk("stream_valid", 32'(out_valid), 32'(c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) chk("stream_data", 32'(out_data), 32'(c - 2));
      tick();
    end
    issue_req = 1'b0; res_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("stream_drained", 32'(level), 0);

    // 3: backpressure, credits exhaust at DEPTH
    issue_req = 1'b1;
    gnt_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (issue_gnt) gnt_cnt++;
      tick();
    end
    issue_req = 1'b0;
    chk("bp_grants", 32'(gnt_cnt), 4);
    chk("bp_gnt_low", 32'(issue_gnt), 0);
    res_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      res_data = 8'(8'h11 + k);
      tick();
    end
    res_valid = 1'b0;
    chk("bp_level4", 32'(level), 4);
    chk("bp_head", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    chk("bp_gnt_same_cycle", 32'(issue_gnt), 0);
    tick();
    out_ready = 1'b0;
    chk("bp_gnt_next_cycle", 32'(issue_gnt), 1);
    chk("bp_level3", 32'(level), 3);
    chk("bp_head2", 32'(out_data), 32'h12);

    // 4: full reservations with simultaneous push and pop
    issue_req = 1'b1;
    tick();
    issue_req = 1'b0;
    chk("full_gnt", 32'(issue_gnt), 0);
    res_valid = 1'b1; res_data = 8'hAA; out_ready = 1'b1;
    tick();
    res_valid = 1'b0; out_ready = 1'b0;
    chk("pp_level", 32'(level), 3);
    chk("pp_err", 32'(err_unexp), 0);
    out_ready = 1'b1;
    chk("pp_d0", 32'(out_data), 32'h13); tick();
    chk("pp_d1", 32'(out_data), 32'h14); tick();
    chk("pp_d2", 32'(out_data), 32'hAA); tick();
    out_ready = 1'b0;
    chk("pp_empty", 32'(out_valid), 0);
    chk("pp_err_end", 32'(err_unexp), 0);

    // 1b: asynchronous reset mid-burst
    issue_req = 1'b1; tick(); tick(); issue_req = 1'b0;
    res_valid = 1'b1; res_data = 8'h21; tick(); res_data = 8'h22; tick(); res_valid = 1'b0;
    chk("mid_level_pre", 32'(level), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_level_async", 32'(level), 0);
    chk("mid_valid_async", 32'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 5: result with no reservation
    res_valid = 1'b1; res_data = 8'h55;
    tick();
    res_valid = 1'b0;
    chk("unexp_level", 32'(level), 0);
    chk("unexp_valid", 32'(out_valid), 0);
    chk("unexp_err", 32'(err_unexp), 1);

    // 6: empty-path latency, held stable under stall
    issue_req = 1'b1; tick(); issue_req = 1'b0;
    tick();
    res_valid = 1'b1; res_data = 8'h3C;
    chk("lat_valid_before", 32'(out_valid), 0);
    tick();
    res_valid = 1'b0;
    chk("lat_valid_after", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h3C);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'h3C);
    end
    chk("err_sticky", 32'(err_unexp), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("lat_popped", 32'(out_valid), 0);
    chk("err_still_sticky", 32'(err_unexp), 1);
    rst_n = 1'b0; #1;
    chk("err_cleared", 32'(err_unexp), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_gnt", 32'(issue_gnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
